// File: rtl/sha256_message_padder.sv
// sha256_message_padder: pads a 32-bit word stream into SHA-256 blocks written as 16 words into scheduler memory
module sha256_message_padder #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic [31:0] blk_word,
  output logic [3:0]  blk_addr,
  output logic        blk_we,
  output logic        blk_first,
  output logic        blk_done,
  output logic        blk_final,
  input  logic        blk_ack
);
  typedef enum logic [2:0] {DATA, PAD80, ZERO, LEN_HI, LEN_LO, DONE, WAIT_ACK} state_t;
  state_t state, state_n, resume, resume_n;
  logic [3:0] idx, idx_n;
  logic [LEN_W-1:0] bits, bits_n;
  logic spill, spill_n, fin, fin_n, wr;
  logic [31:0] word;
  logic [5:0] sh;
  assign in_ready = state == DATA && !reset;
  assign sh = {in_nbytes, 3'b000};
  // spill: the 0x80 landed at word 14/15, so the length goes into an extra block
  always_comb begin
    state_n = state;
    resume_n = resume;
    idx_n = idx;
    bits_n = bits;
    spill_n = spill;
    fin_n = fin;
    wr = 1'b0;
    word = '0;
    case (state)
      DATA: if (in_valid) begin
        wr = 1'b1;
        word = (in_data & ~(32'hffff_ffff >> sh)) | (32'h8000_0000 >> sh);
        bits_n = bits + LEN_W'(sh);
        if (in_last && in_nbytes != 3'd4) begin
          state_n = idx == 4'd15 ? DONE : idx == 4'd13 ? LEN_HI : ZERO;
          spill_n = idx >= 4'd14;
          resume_n = ZERO;
        end else if (idx == 4'd15) begin
          state_n = DONE;
          resume_n = in_last ? PAD80 : DATA;
        end else if (in_last) state_n = PAD80;
      end
      PAD80: begin
        wr = 1'b1;
        word = 32'h8000_0000;
        state_n = idx == 4'd15 ? DONE : idx == 4'd13 ? LEN_HI : ZERO;
        spill_n = idx >= 4'd14;
        resume_n = ZERO;
      end
      ZERO: begin
        wr = 1'b1;
        state_n = idx == 4'd15 ? DONE : (!spill && idx == 4'd13) ? LEN_HI : ZERO;
        resume_n = ZERO;
      end
      LEN_HI: begin
        wr = 1'b1;
        word = bits[LEN_W-1 -: 32];
        state_n = LEN_LO;
      end
      LEN_LO: begin
        wr = 1'b1;
        word = bits[31:0];
        state_n = DONE;
        fin_n = 1'b1;
      end
      DONE: state_n = WAIT_ACK;
      WAIT_ACK: if (blk_ack) begin
        state_n = fin ? DATA : resume;
        spill_n = 1'b0;
        fin_n = 1'b0;
        if (fin) begin
          bits_n = '0;
          idx_n = '0;
        end
      end
      default: state_n = DATA;
    endcase
    if (wr) idx_n = idx + 4'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DATA;
      resume <= DATA;
      idx <= '0;
      bits <= '0;
      spill <= 1'b0;
      fin <= 1'b0;
      blk_word <= '0;
      blk_addr <= '0;
      blk_we <= 1'b0;
      blk_first <= 1'b0;
      blk_done <= 1'b0;
      blk_final <= 1'b0;
    end else begin
      state <= state_n;
      resume <= resume_n;
      idx <= idx_n;
      bits <= bits_n;
      spill <= spill_n;
      fin <= fin_n;
      blk_word <= word;
      blk_addr <= idx;
      blk_we <= wr;
      blk_first <= wr && idx == 4'd0;
      blk_done <= state == DONE;
      blk_final <= state == DONE && fin;
    end
  end
endmodule

// File: tb/tb_sha256_message_padder.sv
// tb_sha256_message_padder: scoreboard bench; a byte-level SHA-256 padding model predicts every block write
module tb_sha256_message_padder;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, blk_ack = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0] in_nbytes = '0;
  logic in_ready, blk_we, blk_first, blk_done, blk_final;
  logic [31:0] blk_word;
  logic [3:0] blk_addr;
  typedef struct packed {logic [3:0] addr; logic [31:0] word;} exp_t;
  exp_t exp_q[$];
  logic fin_q[$];
  logic [7:0] msg[$];
  int n_cmp = 0, n_bad = 0, ack_delay = 0;
  logic ack_busy = 1'b0;

  sha256_message_padder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes), .blk_word(blk_word), .blk_addr(blk_addr),
    .blk_we(blk_we), .blk_first(blk_first), .blk_done(blk_done), .blk_final(blk_final),
    .blk_ack(blk_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (blk_we === 1'b1) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_bad++;
          $error("FAIL extra_write: observed write at addr %0d expected none", blk_addr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("addr", 64'(blk_addr), 64'(e.addr));
          check("word", 64'(blk_word), 64'(e.word));
          check("first", 64'(blk_first), 64'(e.addr == 4'd0));
        end
      end
      if (blk_done === 1'b1) begin
        n_cmp++;
        assert (fin_q.size() != 0) else begin
          n_bad++;
          $error("FAIL extra_done: observed blk_done expected none");
        end
        if (fin_q.size() != 0) check("final", 64'(blk_final), 64'(fin_q.pop_front()));
      end
    end
  end

  initial begin : acker
    forever begin
      @(negedge clk);
      if (blk_done === 1'b1) begin
        ack_busy = 1'b1;
        for (int i = 0; i < ack_delay; i++) begin
          check("wait_we", 64'(blk_we), 0);
          check("wait_ready", 64'(in_ready), 0);
          @(negedge clk);
        end
        blk_ack = 1'b1;
        @(negedge clk);
        blk_ack = 1'b0;
        ack_busy = 1'b0;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_nbytes = nb;
    in_last = last;
    while (in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    assert (t < 300) else begin
      n_bad++;
      $error("FAIL ready_timeout: observed %0d cycles expected < 300", t);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || fin_q.size() != 0 || ack_busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    assert (t < 2000) else begin
      n_bad++;
      $error("FAIL drain_timeout: observed %0d writes pending expected 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_msg(input int gap);
    logic [7:0] p[$];
    logic [63:0] len;
    logic [31:0] w;
    int n, nw, nb, nblk;
    n = msg.size();
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = 64'(n) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < 16; k++)
        exp_q.push_back(exp_t'({4'(k), p[64*b+4*k], p[64*b+4*k+1], p[64*b+4*k+2], p[64*b+4*k+3]}));
      fin_q.push_back(b == nblk - 1);
    end
    nw = n == 0 ? 1 : (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      nb = n - 4*k > 4 ? 4 : n - 4*k;
      for (int j = 0; j < 4; j++) begin
        if (j < nb) w[31-8*j -: 8] = msg[4*k+j];
        else w[31-8*j -: 8] = 8'hA5;
      end
      if (gap > 0 && k % gap == gap - 1) repeat (2) @(negedge clk);
      send_word(w, 3'(nb), k == nw - 1);
    end
    drain();
  endtask

  task automatic set_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'(i * 7 + 3));
  endtask

  task automatic set_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  initial begin
    logic [31:0] w;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(in_ready), 0);
    check("rst_we", 64'(blk_we), 0);
    check("rst_word", 64'(blk_word), 0);
    check("rst_addr", 64'(blk_addr), 0);
    check("rst_first", 64'(blk_first), 0);
    check("rst_done", 64'(blk_done), 0);
    check("rst_final", 64'(blk_final), 0);
    reset = 1'b0;
    #1 check("ready_after_rst", 64'(in_ready), 1);
    @(negedge clk);
    set_abc();
    run_msg(0);
    set_msg(0);
    run_msg(0);
    set_msg(55);
    run_msg(0);
    set_msg(56);
    run_msg(0);
    set_msg(58);
    run_msg(0);
    set_msg(61);
    run_msg(0);
    ack_delay = 70;
    set_msg(64);
    run_msg(3);
    ack_delay = 0;
    for (int k = 0; k < 7; k++) begin
      w = (32'(k + 1) * 32'h0101_0101) ^ 32'hC0DE_0000;
      exp_q.push_back(exp_t'({4'(k), w}));
      send_word(w, 3'd4, 1'b0);
    end
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    in_nbytes = 3'd4;
    in_last = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_we", 64'(blk_we), 0);
    check("async_word", 64'(blk_word), 0);
    check("async_addr", 64'(blk_addr), 0);
    check("async_first", 64'(blk_first), 0);
    check("async_ready", 64'(in_ready), 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    drain();
    check("abort_pending", 64'(exp_q.size()), 0);
    set_abc();
    run_msg(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sha256_message_padder.md
Name: sha256_message_padder

Overview:
Upstream feeder for the SHA-256 message scheduler.
- Accepts a big-endian 32-bit word stream with valid/ready.
- Applies SHA-256 padding: the 0x80 byte, zero fill, and the 64-bit bit-length.
- Emits 512-bit blocks as 16 sequential word writes (data, address 0..15, write enable) into the scheduler's W memory.
- Holds off the next block until the downstream compression/scheduler stage acknowledges that it has consumed the current one.

Parameters:
- LEN_W, 64, width of the message bit-length counter (fixed by SHA-256; the counter wraps modulo 2^LEN_W).

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  padder can accept an input word this cycle
- in_data  in  32  message word; first byte in [31:24]
- in_last  in  1  this is the final word of the message
- in_nbytes  in  3  valid bytes in the word (0..4). Must be 4 unless in_last; 0 is legal only with in_last.
- blk_word  out  32  word written to scheduler memory
- blk_addr  out  4  word index 0..15 within the block
- blk_we  out  1  write strobe for blk_word/blk_addr
- blk_first  out  1  high with blk_we on word 0 of every block
- blk_done  out  1  one-cycle pulse, registered in the cycle after word 15 is written
- blk_final  out  1  valid with blk_done; this block is the last one of the message
- blk_ack  in  1  downstream has consumed the block; the padder may overwrite memory

Behaviour:
Reset values:
- in_ready=0, blk_word=0, blk_addr=0, blk_we=0, blk_first=0, blk_done=0, blk_final=0.
- State=DATA, word index=0, byte counter=0.
- Reset mid-block aborts the block. No further writes occur until a new message arrives.

States: DATA, PAD80, ZERO, LEN_HI, LEN_LO, DONE, WAIT_ACK.

DATA:
- in_ready=1. An accepted word is registered onto blk_word/blk_we one cycle later (latency 1).
- Bytes at positions >= in_nbytes are forced to zero. If in_nbytes<4, byte position in_nbytes is set to 0x80.
- Byte counter += in_nbytes. Word index increments on every write.
- No write in a cycle with in_valid=0; the index holds.
- in_last with in_nbytes<4 (0x80 already placed): go to ZERO, or to DONE if index was 15.
- in_last with in_nbytes=4: go to PAD80.
- Non-last word at index 15: go to DONE.

PAD80:
- in_ready=0. Writes 0x80000000 at the current index.
- Go to ZERO; go to DONE if this was index 15.

ZERO:
- Writes 0 at each index until index 14, then go to LEN_HI.
- If the 0x80 landed at index 14 or 15 (no room for the length): write zeros through index 15, set a pend_len flag, go to DONE. The next block writes zeros 0..13 and then the length.

LEN_HI / LEN_LO:
- Write bitlen[63:32] at index 14, then bitlen[31:0] at index 15.
- bitlen = bytes*8, computed modulo 2^64.
- Go to DONE with blk_final=1.

DONE:
- blk_done pulses for one cycle. blk_final=1 only for the length-bearing block.
- Go to WAIT_ACK.

WAIT_ACK:
- in_ready=0, no writes.
- On blk_ack:
  - final block: clear the byte counter and index, go to DATA.
  - pend_len set: go to ZERO.
  - otherwise: go to DATA.
- blk_ack arriving in the same cycle as blk_done is accepted. blk_ack in any other state is ignored.

General rules:
- blk_we is high for exactly 16 consecutive-or-stalled writes per block, addresses strictly 0..15 in order.
- blk_first is high only with the addr-0 write.
- in_ready is combinational from state only (DATA and not reset), never from in_valid.

Test Plan:
- "abc" (one word 0x61626300, nbytes=3, last) -> word0=0x61626380, words1-14=0, word15=0x00000018; blk_final=1.
- Empty message (in_nbytes=0, last) -> word0=0x80000000, words1-15=0, blk_final=1.
- 55 bytes (13 full words + 3 bytes) -> one block: word13 low byte 0x80, word14=0, word15=0x000001B8.
- 56 bytes -> two blocks:
  - Block 1: word14=0x80000000, word15=0, blk_final=0.
  - Block 2 (after ack): words 0-14=0, word15=0x000001C0, blk_final=1.
- 64 bytes with in_valid gaps and blk_ack delayed 70 cycles:
  - Block 1 is the data; in_ready stays 0 and no writes occur during WAIT_ACK.
  - Block 2: word0=0x80000000, word15=0x00000200.
- Reset asserted at word 7:
  - All outputs are 0 immediately (asynchronous).
  - A following "abc" message produces exactly the "abc" block, starting at addr 0.
